icache_param: RTL and testbench

- Parametrised successor to the fixed instruction-cache role on the datapath/cache boundary.
- Direct-mapped read-only instruction cache with configurable set count and words per block.
- Multi-word block fill FSM toward the memory controller, plus a single-cycle flush/invalidate input.
- Sits between the datapath fetch port (imemREN/imemaddr -> ihit/imemload) and the memory-controller instruction port (iREN/iaddr <- iwait/iload).

---
 rtl/icache_param.sv | 110 +++++++++++
 tb/tb_icache_param.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/icache_param.sv
// icache_param: direct-mapped read-only instruction cache with multi-word block fill and flush.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_param #(
    parameter int SETS = 16,
    parameter int BLOCK_WORDS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int WO = $clog2(BLOCK_WORDS);
    localparam int IX = $clog2(SETS);
    localparam int TW = 30 - WO - IX;
    localparam int CW = (WO > 0) ? WO : 1;

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, next;

    logic [SETS-1:0] valid;
    logic [TW-1:0]   tags [SETS];
    logic [31:0]     data [SETS][BLOCK_WORDS];
    logic [IX-1:0]   idx, lidx;
    logic [TW-1:0]   tag, ltag;
    logic [CW-1:0]   woff, cnt;
    logic            last, accept, miss;
    logic            unused_addr;

    assign idx         = imemaddr[IX+WO+1:WO+2];
    assign tag         = imemaddr[31:IX+WO+2];
    assign woff        = CW'(imemaddr[31:2] & 30'(BLOCK_WORDS - 1));
    assign last        = cnt == CW'(BLOCK_WORDS - 1);
    assign accept      = (state == FILL) && !iwait;
    assign unused_addr = ^imemaddr[1:0];

    // Hit lookup in IDLE, memory request generation in FILL, and next-state selection.
    always_comb begin
        next     = state;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        miss     = 1'b0;
        if (state == IDLE) begin
            ihit     = imemREN && valid[idx] && (tags[idx] == tag) && !iflush;
            imemload = ihit ? data[idx][woff] : '0;
            miss     = imemREN && !ihit && !iflush;
            next     = miss ? FILL : IDLE;
        end else begin
            iREN  = 1'b1;
            iaddr = {ltag, lidx, {(WO+2){1'b0}}} | (32'(cnt) << 2);
            next  = (iflush || (accept && last)) ? IDLE : FILL;
        end
    end

    // State, latched miss address, fill counter and valid bits; flush wins over fill completion.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            valid <= '0;
            cnt   <= '0;
            ltag  <= '0;
            lidx  <= '0;
        end else begin
            state <= next;
            if (miss) begin
                ltag <= tag;
                lidx <= idx;
                cnt  <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
            if (iflush) valid <= '0;
            else if (accept && last) valid[lidx] <= 1'b1;
        end
    end

    // Data and tag arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge CLK) begin
        if (accept) begin
            data[lidx][cnt] <= iload;
            if (last) tags[lidx] <= ltag;
        end
    end

`ifdef ICACHE_STATS_EN
    // Free-running hit and miss counters, untouched by flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit) hit_count <= hit_count + 1'b1;
            if (miss) miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_param.sv
// tb_icache_param: directed and randomized checks of icache_param against a line-level cache model.
module tb_icache_param;
    logic        CLK = 1'b0;
    logic        nRST, imemREN, iflush, iwait, ihit, iREN;
    logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif
    int          total = 0;
    int          bad = 0;
    int          mhits = 0;
    int          mmiss = 0;
    logic [31:0] base;
    bit          mv [16];
    logic [24:0] mt [16];
    logic [31:0] md [16][2];

    icache_param #(.SETS(16), .BLOCK_WORDS(2)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tg, obs, want);
        end
    endtask

    task automatic clear_model;
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    // One fetch of address a; memory inserts ws wait cycles per word on a miss.
    task automatic access(input logic [31:0] a, input int ws);
        int ix, wo, n, w, k;
        logic [24:0] tg;
        logic [31:0] ea;
        bit hit;
        ix = int'(a[6:3]);
        wo = int'(a[2]);
        tg = a[31:7];
        hit = mv[ix] && mt[ix] == tg;
        imemREN = 1'b1;
        imemaddr = a;
        iflush = 1'b0;
        if (!hit) begin
            n = 0; w = 0; k = 0;
            while (n < 60) begin
                ea = {a[31:3], 3'b000} | 32'(w << 2);
                iwait = (k < ws);
                iload = base ^ ea;
                #4;
                if (ihit) break;
                if (n == 0) chk("miss_ren", {31'd0, iREN}, 32'd0);
                if (iREN) begin
                    chk("fill_iaddr", iaddr, ea);
                    if (!iwait) begin
                        if (w < 2) md[ix][w] = iload;
                        w++;
                        k = 0;
                    end else k++;
                end
                tick;
                n++;
            end
            chk("miss_latency", 32'(n), 32'(1 + 2 * (ws + 1)));
            mv[ix] = 1'b1;
            mt[ix] = tg;
            mmiss++;
        end else #4;
        chk("hit", {31'd0, ihit}, 32'd1);
        chk("hit_load", imemload, md[ix][wo]);
        chk("hit_ren", {31'd0, iREN}, 32'd0);
        mhits++;
        tick;
        imemREN = 1'b0;
        iwait = 1'b0;
    endtask

    initial begin
        nRST = 1'b1; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b0; iload = '0; base = '0;
        clear_model();
        #1 nRST = 1'b0;
        #1;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_load", imemload, 32'd0);
        tick;
        tick;
        nRST = 1'b1;

        base = 32'hAAAA0040;
        access(32'h40, 0);
        imemREN = 1'b1; imemaddr = 32'h44;
        #4;
        chk("t2_hit", {31'd0, ihit}, 32'd1);
        chk("t2_load", imemload, 32'hAAAA0004);
        chk("t2_ren", {31'd0, iREN}, 32'd0);
        mhits++;
        tick;
        imemREN = 1'b0;
`ifdef ICACHE_STATS_EN
        chk("t2_hit_count", hit_count, 32'd2);
        chk("t2_miss_count", miss_count, 32'd1);
`endif

        access(32'h80, 3);
        access(32'h440, 0);
        access(32'h40, 0);

        access(32'h440, 0);
        imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b0; iload = base ^ 32'h40;
        #4 chk("t5_miss", {31'd0, ihit}, 32'd0);
        tick;
        mmiss++;
        iflush = 1'b1;
        #4 chk("t5_ren_fill", {31'd0, iREN}, 32'd1);
        tick;
        iflush = 1'b0; imemREN = 1'b0;
        #4 chk("t5_ren_drop", {31'd0, iREN}, 32'd0);
        clear_model();
        tick;
        access(32'h40, 0);
        access(32'h40, 0);
        imemREN = 1'b1; imemaddr = 32'h40; iflush = 1'b1;
        #4 chk("t5_idle_flush", {31'd0, ihit}, 32'd0);
        tick;
        iflush = 1'b0; imemREN = 1'b0;
        clear_model();
        access(32'h40, 0);

        imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b0; iload = base ^ 32'h100;
        tick;
        mmiss++;
        iload = base ^ 32'h104;
        tick;
        iflush = 1'b1;
        #4;
        chk("t5_last_ren", {31'd0, iREN}, 32'd1);
        chk("t5_last_iaddr", iaddr, 32'h104);
        tick;
        iflush = 1'b0; imemREN = 1'b0;
        clear_model();
        access(32'h100, 1);
        access(32'h40, 0);

        imemREN = 1'b1; imemaddr = 32'h200; iload = base ^ 32'h200;
        tick;
        #2 nRST = 1'b0;
        #1;
        chk("t6_iren", {31'd0, iREN}, 32'd0);
        chk("t6_ihit", {31'd0, ihit}, 32'd0);
        chk("t6_load", imemload, 32'd0);
        chk("t6_iaddr", iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
        chk("t6_hit_count", hit_count, 32'd0);
        chk("t6_miss_count", miss_count, 32'd0);
`endif
        tick;
        nRST = 1'b1; imemREN = 1'b0;
        clear_model();
        mhits = 0; mmiss = 0;
        access(32'h200, 0);
        access(32'h40, 2);

        repeat (150) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 3) << 7) | 32'($urandom_range(0, 15) << 3) | 32'($urandom_range(0, 1) << 2);
            if ($urandom_range(0, 31) == 0) base = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                imemREN = 1'($urandom_range(0, 1)); imemaddr = a; iflush = 1'b1;
                #4 chk("rnd_flush_ihit", {31'd0, ihit}, 32'd0);
                tick;
                iflush = 1'b0; imemREN = 1'b0;
                clear_model();
            end
            access(a, $urandom_range(0, 2));
        end
`ifdef ICACHE_STATS_EN
        chk("end_hit_count", hit_count, 32'(mhits));
        chk("end_miss_count", miss_count, 32'(mmiss));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
